// File: rtl/fft_job_sched.sv
// Round-robin job scheduler for a two-requester FFT engine: arbitrates, latches the
// job config, then sequences the config/input/output phases with a per-phase timeout.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a request; arbitration happens here only
// S_CFG      | grant pulse to requester and config commit pulse (1 cycle)
// S_CFG_WAIT | waiting for the config stream handshake
// S_TRIG     | input-stream trigger pulse (1 cycle)
// S_IN_WAIT  | waiting for the last beat of the input frame
// S_OUT_WAIT | waiting for the output frame capture
// S_DONE     | completion pulse to requester, err=0 (1 cycle)
// S_ABORT    | timeout: core reset plus completion pulse with err=1 (1 cycle)
module fft_job_sched #(
   parameter int SCALE_SCH_WIDTH = 4,
   parameter int TIMEOUT         = 4096
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [1:0]                   req_valid,
   input  logic [1:0]                   req_forward,
   input  logic [2*SCALE_SCH_WIDTH-1:0] req_scale,
   output logic [1:0]                   req_ready,
   output logic [1:0]                   done,
   output logic                         err,
   output logic                         grant_id,
   output logic                         busy,
   output logic                         cfg_forward,
   output logic [SCALE_SCH_WIDTH-1:0]   cfg_scale,
   output logic                         cfg_commit,
   input  logic                         cfg_tvalid,
   input  logic                         cfg_tready,
   output logic                         in_trig,
   input  logic                         in_tvalid,
   input  logic                         in_tready,
   input  logic                         in_tlast,
   input  logic                         out_received,
   output logic                         core_rst
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_CFG_WAIT, S_TRIG, S_IN_WAIT, S_OUT_WAIT, S_DONE, S_ABORT
   } state_t;

   localparam int          W       = SCALE_SCH_WIDTH;
   localparam logic [15:0] TC_LAST = 16'(TIMEOUT - 1);

   state_t              state, state_nxt;
   logic [15:0]         tmo_cnt;
   logic                last_grant;
   logic                win;
   logic                tmo_hit;
   logic                grant_nxt;
   logic                fwd_nxt;
   logic [W-1:0]        scale_nxt;
   logic                in_wait_state;

   always_comb begin
      win = req_valid[1];
      if (req_valid == 2'b11) begin
         win = ~last_grant;
      end
   end

   assign tmo_hit       = (tmo_cnt == TC_LAST);
   assign in_wait_state = (state == S_CFG_WAIT) || (state == S_IN_WAIT) || (state == S_OUT_WAIT);

   // Events win over a coinciding timeout, so the event test comes first in each wait state.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      fwd_nxt   = cfg_forward;
      scale_nxt = cfg_scale;
      case (state)
         S_IDLE: begin
            if (|req_valid) begin
               state_nxt = S_CFG;
               grant_nxt = win;
               fwd_nxt   = win ? req_forward[1] : req_forward[0];
               scale_nxt = win ? req_scale[2*W-1:W] : req_scale[W-1:0];
            end
         end
         S_CFG:      state_nxt = S_CFG_WAIT;
         S_CFG_WAIT: begin
            if (cfg_tvalid && cfg_tready) state_nxt = S_TRIG;
            else if (tmo_hit)             state_nxt = S_ABORT;
         end
         S_TRIG:     state_nxt = S_IN_WAIT;
         S_IN_WAIT: begin
            if (in_tvalid && in_tready && in_tlast) state_nxt = S_OUT_WAIT;
            else if (tmo_hit)                       state_nxt = S_ABORT;
         end
         S_OUT_WAIT: begin
            if (out_received)  state_nxt = S_DONE;
            else if (tmo_hit)  state_nxt = S_ABORT;
         end
         S_DONE:     state_nxt = S_IDLE;
         S_ABORT:    state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         tmo_cnt    <= '0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            tmo_cnt <= '0;
         end else if (in_wait_state) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end
         if ((state == S_DONE) || (state == S_ABORT)) begin
            last_grant <= grant_id;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         req_ready   <= '0;
         done        <= '0;
         err         <= 1'b0;
         grant_id    <= 1'b0;
         busy        <= 1'b0;
         cfg_forward <= 1'b0;
         cfg_scale   <= '0;
         cfg_commit  <= 1'b0;
         in_trig     <= 1'b0;
         core_rst    <= 1'b0;
      end else begin
         grant_id    <= grant_nxt;
         cfg_forward <= fwd_nxt;
         cfg_scale   <= scale_nxt;
         req_ready   <= (state_nxt == S_CFG) ? {grant_nxt, ~grant_nxt} : 2'b00;
         done        <= ((state_nxt == S_DONE) || (state_nxt == S_ABORT)) ?
                        {grant_nxt, ~grant_nxt} : 2'b00;
         err         <= (state_nxt == S_ABORT);
         core_rst    <= (state_nxt == S_ABORT);
         busy        <= (state_nxt != S_IDLE);
         cfg_commit  <= (state_nxt == S_CFG);
         in_trig     <= (state_nxt == S_TRIG);
      end
   end

endmodule

// File: tb/tb_fft_job_sched.sv
// Directed bench for fft_job_sched: arbitration order, config latching, phase
// timeouts, event/timeout tie, reset mid-job and stray event rejection.
module tb_fft_job_sched;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] req_valid;
   logic [1:0] req_forward;
   logic [7:0] req_scale;
   logic [1:0] req_ready;
   logic [1:0] done;
   logic       err;
   logic       grant_id;
   logic       busy;
   logic       cfg_forward;
   logic [3:0] cfg_scale;
   logic       cfg_commit;
   logic       cfg_tvalid;
   logic       cfg_tready;
   logic       in_trig;
   logic       in_tvalid;
   logic       in_tready;
   logic       in_tlast;
   logic       out_received;
   logic       core_rst;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int grant_cyc;

   fft_job_sched #(.SCALE_SCH_WIDTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_forward(req_forward), .req_scale(req_scale),
      .req_ready(req_ready), .done(done), .err(err), .grant_id(grant_id), .busy(busy),
      .cfg_forward(cfg_forward), .cfg_scale(cfg_scale), .cfg_commit(cfg_commit),
      .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .in_trig(in_trig),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
      .out_received(out_received), .core_rst(core_rst)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // From a CFG sample: every handshake arrives one cycle after its wait state is entered.
   // Returns sampling the DONE cycle.
   task automatic drive_job();
      step();
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      step();
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      out_received = 1'b1;
      step();
      out_received = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      step();
      step();
      total++;
      if ({busy, req_ready, done, err, cfg_commit, in_trig, core_rst} !== 9'b0) begin
         bad++; $display("FAIL reset_pulses: got %b want 000000000",
                         {busy, req_ready, done, err, cfg_commit, in_trig, core_rst});
      end
      total++;
      if ({grant_id, cfg_forward, cfg_scale} !== 6'b0) begin
         bad++; $display("FAIL reset_cfg: got %b want 000000", {grant_id, cfg_forward, cfg_scale});
      end
   endtask

   task automatic test_round_robin();
      req_valid = 2'b11; req_forward = 2'b01; req_scale = 8'h53;
      resetn = 1'b1;
      step();
      grant_cyc = cyc;
      total++;
      if ({req_ready, cfg_commit, grant_id, cfg_forward, cfg_scale, busy} !== {2'b01, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1}) begin
         bad++; $display("FAIL rr_grant0: got rdy=%b com=%b gid=%b fwd=%b scl=%h busy=%b want 01 1 0 1 3 1",
                         req_ready, cfg_commit, grant_id, cfg_forward, cfg_scale, busy);
      end
      step();
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      total++;
      if ({in_trig, req_ready, cfg_commit} !== 4'b1000) begin
         bad++; $display("FAIL rr_trig: got trig=%b rdy=%b com=%b want 1 00 0", in_trig, req_ready, cfg_commit);
      end
      step();
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      out_received = 1'b1;
      step();
      out_received = 1'b0;
      total++;
      if ({done, err, req_ready} !== 5'b01000) begin
         bad++; $display("FAIL rr_done0: got done=%b err=%b rdy=%b want 01 0 00", done, err, req_ready);
      end
      total++;
      if (cyc - grant_cyc + 1 != 6) begin
         bad++; $display("FAIL rr_len0: got %0d cycles want 6", cyc - grant_cyc + 1);
      end
      step();
      total++;
      if ({busy, done} !== 3'b000) begin
         bad++; $display("FAIL rr_idle: got busy=%b done=%b want 0 00", busy, done);
      end
      step();
      grant_cyc = cyc;
      total++;
      if ({req_ready, grant_id, cfg_forward, cfg_scale} !== {2'b10, 1'b1, 1'b0, 4'h5}) begin
         bad++; $display("FAIL rr_grant1: got rdy=%b gid=%b fwd=%b scl=%h want 10 1 0 5",
                         req_ready, grant_id, cfg_forward, cfg_scale);
      end
      req_valid = 2'b00;
      drive_job();
      total++;
      if ({done, err} !== 3'b100) begin
         bad++; $display("FAIL rr_done1: got done=%b err=%b want 10 0", done, err);
      end
      total++;
      if (cyc - grant_cyc + 1 != 6) begin
         bad++; $display("FAIL rr_len1: got %0d cycles want 6", cyc - grant_cyc + 1);
      end
      step();
   endtask

   task automatic test_cfg_latch();
      req_valid = 2'b10; req_forward = 2'b10; req_scale = 8'hA0;
      step();
      total++;
      if ({req_ready, cfg_forward, cfg_scale} !== {2'b10, 1'b1, 4'hA}) begin
         bad++; $display("FAIL latch_grant: got rdy=%b fwd=%b scl=%h want 10 1 a", req_ready, cfg_forward, cfg_scale);
      end
      req_valid = 2'b00; req_scale = 8'h30; req_forward = 2'b00;
      step();
      step();
      total++;
      if ({cfg_forward, cfg_scale} !== {1'b1, 4'hA}) begin
         bad++; $display("FAIL latch_hold: got fwd=%b scl=%h want 1 a", cfg_forward, cfg_scale);
      end
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      step();
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      out_received = 1'b1;
      step();
      out_received = 1'b0;
      total++;
      if ({done, err} !== 3'b100) begin
         bad++; $display("FAIL latch_done: got done=%b err=%b want 10 0", done, err);
      end
      step();
   endtask

   task automatic test_timeout();
      logic early;
      req_valid = 2'b01; req_forward = 2'b00; req_scale = 8'h00;
      step();
      req_valid = 2'b00;
      step();
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      step();
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      early = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (done != 2'b00 || core_rst || !busy) early = 1'b1;
      end
      total++;
      if (early) begin
         bad++; $display("FAIL tmo_early: got early abort=1 want 0");
      end
      step();
      total++;
      if ({core_rst, done, err} !== 4'b1011) begin
         bad++; $display("FAIL tmo_abort: got rst=%b done=%b err=%b want 1 01 1", core_rst, done, err);
      end
      step();
      total++;
      if ({busy, core_rst, done, err} !== 5'b0) begin
         bad++; $display("FAIL tmo_idle: got busy=%b rst=%b done=%b err=%b want 0 0 00 0", busy, core_rst, done, err);
      end
   endtask

   task automatic test_event_wins();
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      step();
      for (int i = 1; i <= 7; i++) step();
      in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      total++;
      if ({busy, core_rst, done, err} !== 5'b10000) begin
         bad++; $display("FAIL tie_no_abort: got busy=%b rst=%b done=%b err=%b want 1 0 00 0", busy, core_rst, done, err);
      end
      out_received = 1'b1;
      step();
      out_received = 1'b0;
      total++;
      if ({done, err, core_rst} !== 4'b0100) begin
         bad++; $display("FAIL tie_done: got done=%b err=%b rst=%b want 01 0 0", done, err, core_rst);
      end
      step();
   endtask

   task automatic test_reset_mid_job();
      logic spurious;
      req_valid = 2'b11; req_scale = 8'h7E; req_forward = 2'b11;
      step();
      total++;
      if ({req_ready, grant_id} !== 3'b101) begin
         bad++; $display("FAIL mid_grant1: got rdy=%b gid=%b want 10 1", req_ready, grant_id);
      end
      step();
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      step();
      resetn = 1'b0;
      step();
      total++;
      if ({busy, req_ready, done, err, cfg_commit, in_trig, core_rst, grant_id, cfg_forward, cfg_scale} !== 15'b0) begin
         bad++; $display("FAIL mid_reset: got %b want all zero",
                         {busy, req_ready, done, err, cfg_commit, in_trig, core_rst, grant_id, cfg_forward, cfg_scale});
      end
      resetn = 1'b1;
      step();
      total++;
      if ({req_ready, grant_id, cfg_scale} !== {2'b01, 1'b0, 4'hE}) begin
         bad++; $display("FAIL mid_regrant: got rdy=%b gid=%b scl=%h want 01 0 e", req_ready, grant_id, cfg_scale);
      end
      req_valid = 2'b00;
      spurious = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done != 2'b00 || core_rst) spurious = 1'b1;
      end
      total++;
      if (spurious) begin
         bad++; $display("FAIL mid_quiet: got done/core_rst=1 want 0");
      end
   endtask

   task automatic test_stray_events();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      req_valid = 2'b00;
      out_received = 1'b1;
      step();
      out_received = 1'b0;
      total++;
      if ({busy, done, req_ready} !== 5'b0) begin
         bad++; $display("FAIL stray_idle: got busy=%b done=%b rdy=%b want 0 00 00", busy, done, req_ready);
      end
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      out_received = 1'b1; in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
      step();
      out_received = 1'b0; in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
      total++;
      if ({busy, done, in_trig} !== 4'b1000) begin
         bad++; $display("FAIL stray_cfgwait: got busy=%b done=%b trig=%b want 1 00 0", busy, done, in_trig);
      end
      cfg_tvalid = 1'b1; cfg_tready = 1'b1;
      step();
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      total++;
      if (in_trig !== 1'b1) begin
         bad++; $display("FAIL stray_trig: got trig=%b want 1", in_trig);
      end
   endtask

   initial begin
      resetn = 1'b0; req_valid = 2'b00; req_forward = 2'b00; req_scale = 8'h00;
      cfg_tvalid = 1'b0; cfg_tready = 1'b0;
      in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0; out_received = 1'b0;
      test_reset();
      test_round_robin();
      test_cfg_latch();
      test_timeout();
      test_event_wins();
      test_reset_mid_job();
      test_stray_events();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
